// File: rtl/forward_kinematics.sv
// Two-link arm forward kinematics: joint angles -> clamped end-effector (x, y).
// One shared rotation-mode CORDIC engine runs once per link, then the link vectors are summed.
`timescale 1ns/1ps
module forward_kinematics #(
   parameter int unsigned L1   = 100,
   parameter int unsigned L2   = 100,
   parameter int unsigned ITER = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [23:0] i_shoulder_angle,
   input  logic [23:0] i_elbow_angle,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_x,
   output logic [7:0]  o_y,
   output logic        o_out_of_range
);

   localparam int unsigned AW    = 24;
   localparam int unsigned DW    = 26;
   localparam int unsigned SW    = 27;
   localparam int unsigned IW    = 11;
   localparam int unsigned CW    = 5;
   localparam int unsigned K_Q16 = 39797;

   localparam logic signed [DW-1:0] LK1 = DW'(L1 * K_Q16);
   localparam logic signed [DW-1:0] LK2 = DW'(L2 * K_Q16);

   typedef enum logic [1:0] {S_IDLE, S_ROT1, S_ROT2, S_FINISH} state_t;

   // atan(2^-i) as a binary angle, 2^24 = one turn
   function automatic logic [AW-1:0] atan_lut(input logic [CW-1:0] i);
      case (i)
         5'd0:    atan_lut = 24'h200000;
         5'd1:    atan_lut = 24'h12E405;
         5'd2:    atan_lut = 24'h09FB38;
         5'd3:    atan_lut = 24'h051112;
         5'd4:    atan_lut = 24'h028B0D;
         5'd5:    atan_lut = 24'h0145D8;
         5'd6:    atan_lut = 24'h00A2F6;
         5'd7:    atan_lut = 24'h00517C;
         5'd8:    atan_lut = 24'h0028BE;
         5'd9:    atan_lut = 24'h00145F;
         5'd10:   atan_lut = 24'h000A30;
         5'd11:   atan_lut = 24'h000518;
         5'd12:   atan_lut = 24'h00028C;
         5'd13:   atan_lut = 24'h000146;
         5'd14:   atan_lut = 24'h0000A3;
         5'd15:   atan_lut = 24'h000051;
         5'd16:   atan_lut = 24'h000029;
         5'd17:   atan_lut = 24'h000014;
         5'd18:   atan_lut = 24'h00000A;
         5'd19:   atan_lut = 24'h000005;
         default: atan_lut = 24'h000000;
      endcase
   endfunction

   // Returns {out_of_range, clamped 8-bit value}
   function automatic logic [8:0] clamp_u8(input logic signed [IW-1:0] v);
      if (v[IW-1])
         clamp_u8 = {1'b1, 8'd0};
      else if (v[IW-2:8] != '0)
         clamp_u8 = {1'b1, 8'd255};
      else
         clamp_u8 = {1'b0, v[7:0]};
   endfunction

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [AW-1:0]         r_th2;
   logic signed [DW-1:0]  r_x, r_y, r_x1, r_y1;
   logic [AW-1:0]         r_z;
   logic                  r_busy, r_done, r_oor;
   logic [7:0]            r_xo, r_yo;

   logic [AW-1:0]         w_load_a, w_load_z, w_at;
   logic signed [DW-1:0]  w_load_l, w_load_x;
   logic                  w_flip;
   logic signed [DW-1:0]  w_dx, w_dy, w_x_nx, w_y_nx;
   logic [AW-1:0]         w_z_nx;
   logic signed [SW-1:0]  w_sum_x, w_sum_y;
   logic signed [IW-1:0]  w_int_x, w_int_y;
   logic [8:0]            w_cx, w_cy;

   // Engine load: link 1 from the live shoulder angle in IDLE, link 2 from the latched sum
   always_comb begin
      w_load_a = (r_state == S_IDLE) ? i_shoulder_angle : r_th2;
      w_load_l = (r_state == S_IDLE) ? LK1 : LK2;
      w_flip   = w_load_a[AW-1] ^ w_load_a[AW-2];
      w_load_x = w_flip ? -w_load_l : w_load_l;
      w_load_z = w_flip ? w_load_a + 24'h800000 : w_load_a;
   end

   // One CORDIC micro-rotation, direction chosen by the sign of the residual angle
   always_comb begin
      w_dx = r_x >>> r_cnt;
      w_dy = r_y >>> r_cnt;
      w_at = atan_lut(r_cnt);
      if (r_z[AW-1]) begin
         w_x_nx = r_x + w_dy;
         w_y_nx = r_y - w_dx;
         w_z_nx = r_z + w_at;
      end else begin
         w_x_nx = r_x - w_dy;
         w_y_nx = r_y + w_dx;
         w_z_nx = r_z - w_at;
      end
   end

   // Sum both link vectors, round half up to integer, clamp to 0..255
   always_comb begin
      w_sum_x = SW'(r_x1) + SW'(r_x);
      w_sum_y = SW'(r_y1) + SW'(r_y);
      w_int_x = IW'((w_sum_x + SW'(32'sd32768)) >>> 16);
      w_int_y = IW'((w_sum_y + SW'(32'sd32768)) >>> 16);
      w_cx    = clamp_u8(w_int_x);
      w_cy    = clamp_u8(w_int_y);
   end

   // Control FSM and datapath registers; ROT1 spends one extra cycle handing off to link 2
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_th2   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_oor   <= 1'b0;
         r_xo    <= '0;
         r_yo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_th2   <= i_shoulder_angle + i_elbow_angle;
                  r_x     <= w_load_x;
                  r_y     <= '0;
                  r_z     <= w_load_z;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ROT1;
               end
            end
            S_ROT1: begin
               if (r_cnt == CW'(ITER)) begin
                  r_x1    <= r_x;
                  r_y1    <= r_y;
                  r_x     <= w_load_x;
                  r_y     <= '0;
                  r_z     <= w_load_z;
                  r_cnt   <= '0;
                  r_state <= S_ROT2;
               end else begin
                  r_x   <= w_x_nx;
                  r_y   <= w_y_nx;
                  r_z   <= w_z_nx;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ROT2: begin
               r_x   <= w_x_nx;
               r_y   <= w_y_nx;
               r_z   <= w_z_nx;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(ITER - 1))
                  r_state <= S_FINISH;
            end
            S_FINISH: begin
               r_xo    <= w_cx[7:0];
               r_yo    <= w_cy[7:0];
               r_oor   <= w_cx[8] | w_cy[8];
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_x            = r_xo;
   assign o_y            = r_yo;
   assign o_out_of_range = r_oor;

endmodule
